// File: rtl/wb_regfile_if.sv
// Writeback / register-read bus between the pipeline's W and D stages and the register file.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] ReadDataW;
  logic [DATA_W-1:0] AluoutW;
  logic [4:0]        writeRegW;
  logic              RegWriteW;
  logic              MemtoRegW;
  logic [4:0]        ra1;
  logic [4:0]        ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] ResultW;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output ReadDataW, AluoutW, writeRegW, RegWriteW, MemtoRegW, ra1, ra2,
    input  rd1, rd2, ResultW, wr_count
  );

  modport slave (
    input  ReadDataW, AluoutW, writeRegW, RegWriteW, MemtoRegW, ra1, ra2,
    output rd1, rd2, ResultW, wr_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Register file with WB result mux, same-cycle write-through bypass on both read
// ports, and a counter of committed writes. Reads are forced to zero while in reset.

module wb_regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic                        rst,
  input  logic [4:0]                  ra,
  input  logic [NREG-1:0][DATA_W-1:0] regs,
  input  logic                        wen,
  input  logic [4:0]                  wa,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rd
);
  always_comb begin
    rd = '0;
    if (rst && ra != 5'd0 && 32'(ra) < NREG) begin
      // wen already excludes r0, so a match here is always a real write
      if (wen && wa == ra) rd = wdata;
      else                 rd = regs[ra];
    end
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst,
  wb_regfile_if.slave  bus
);
  typedef struct packed {
    logic              en;
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } wbReqT;

  wbReqT                       wb;
  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [CNT_W-1:0]            wrCount;
  logic [1:0][4:0]             raArr;
  logic [1:0][DATA_W-1:0]      rdArr;

  always_comb begin
    wb.data = bus.MemtoRegW ? bus.ReadDataW : bus.AluoutW;
    wb.addr = bus.writeRegW;
    wb.en   = bus.RegWriteW && (bus.writeRegW != 5'd0) && (32'(bus.writeRegW) < NREG);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs    <= '0;
      wrCount <= '0;
    end else if (wb.en) begin
      regs[wb.addr] <= wb.data;
      wrCount       <= wrCount + 1'b1;
    end
  end

  assign raArr        = {bus.ra2, bus.ra1};
  assign bus.rd1      = rdArr[0];
  assign bus.rd2      = rdArr[1];
  assign bus.ResultW  = wb.data;
  assign bus.wr_count = wrCount;

  for (genvar p = 0; p < 2; p++) begin : gRd
    wb_regfile_rdport #(.DATA_W(DATA_W), .NREG(NREG)) uRd (
      .rst   (rst),
      .ra    (raArr[p]),
      .regs  (regs),
      .wen   (wb.en),
      .wa    (wb.addr),
      .wdata (wb.data),
      .rd    (rdArr[p])
    );
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile: table of per-cycle vectors plus reset and wrap sequences.
module tb_wb_regfile;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  wb_regfile_if #(.DATA_W(32), .CNT_W(16)) bus ();

  wb_regfile #(.DATA_W(32), .NREG(32), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [4:0]  wa;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] eRd1;
    logic [31:0] eRd2;
    logic [31:0] eRes;
    logic [15:0] eCnt;
  } vecT;

  vecT vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] mem,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus.RegWriteW = we;
    bus.MemtoRegW = m2r;
    bus.writeRegW = wa;
    bus.AluoutW   = alu;
    bus.ReadDataW = mem;
    bus.ra1       = ra1;
    bus.ra2       = ra2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //            we  m2r wa     alu           mem           ra1    ra2    rd1           rd2           res           cnt
    vecs[0]  = '{1'b1,1'b0,5'd5, 32'h0000_1234,32'h0,        5'd5,  5'd0,  32'h0000_1234,32'h0,        32'h0000_1234,16'd1};
    vecs[1]  = '{1'b0,1'b0,5'd0, 32'h0,        32'h0,        5'd5,  5'd5,  32'h0000_1234,32'h0000_1234,32'h0,        16'd1};
    vecs[2]  = '{1'b1,1'b0,5'd0, 32'hFFFF_FFFF,32'h0,        5'd0,  5'd5,  32'h0,        32'h0000_1234,32'hFFFF_FFFF,16'd1};
    vecs[3]  = '{1'b0,1'b0,5'd0, 32'hFFFF_FFFF,32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'hFFFF_FFFF,16'd1};
    vecs[4]  = '{1'b1,1'b0,5'd7, 32'h0000_0011,32'h0,        5'd7,  5'd3,  32'h0000_0011,32'h0,        32'h0000_0011,16'd2};
    vecs[5]  = '{1'b1,1'b1,5'd7, 32'h0,        32'hDEAD_BEEF,5'd7,  5'd7,  32'hDEAD_BEEF,32'hDEAD_BEEF,32'hDEAD_BEEF,16'd3};
    vecs[6]  = '{1'b0,1'b0,5'd7, 32'h0000_000A,32'h0000_000B,5'd7,  5'd5,  32'hDEAD_BEEF,32'h0000_1234,32'h0000_000A,16'd3};
    vecs[7]  = '{1'b0,1'b1,5'd7, 32'h0000_000A,32'h0000_000B,5'd7,  5'd5,  32'hDEAD_BEEF,32'h0000_1234,32'h0000_000B,16'd3};
    vecs[8]  = '{1'b1,1'b1,5'd31,32'h0,        32'hCAFE_F00D,5'd31, 5'd7,  32'hCAFE_F00D,32'hDEAD_BEEF,32'hCAFE_F00D,16'd4};
    vecs[9]  = '{1'b1,1'b0,5'd1, 32'h0000_0001,32'h0,        5'd31, 5'd1,  32'hCAFE_F00D,32'h0000_0001,32'h0000_0001,16'd5};
    vecs[10] = '{1'b0,1'b0,5'd0, 32'h0,        32'h0,        5'd1,  5'd31, 32'h0000_0001,32'hCAFE_F00D,32'h0,        16'd5};
    vecs[11] = '{1'b1,1'b0,5'd3, 32'h0000_0055,32'h0,        5'd3,  5'd5,  32'h0000_0055,32'h0000_1234,32'h0000_0055,16'd6};

    rst = 1'b0;
    drive(1'b1, 1'b0, 5'd5, 32'h0000_9999, 32'h0, 5'd5, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd1_bypass_off", bus.rd1, 32'h0);
    check("reset_rd2_bypass_off", bus.rd2, 32'h0);
    check("reset_cnt", 32'(bus.wr_count), 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd0);
    rst = 1'b1;
    #1;
    check("post_reset_r5", bus.rd1, 32'h0);

    // table vectors: inputs set mid-cycle, comb outputs checked before the edge, count after
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].we, vecs[i].m2r, vecs[i].wa, vecs[i].alu, vecs[i].mem, vecs[i].ra1, vecs[i].ra2);
      #1;
      check($sformatf("v%0d_rd1", i), bus.rd1, vecs[i].eRd1);
      check($sformatf("v%0d_rd2", i), bus.rd2, vecs[i].eRd2);
      check($sformatf("v%0d_res", i), bus.ResultW, vecs[i].eRes);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_cnt", i), 32'(bus.wr_count), 32'(vecs[i].eCnt));
    end

    // stored value after the bypass vector
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd3);
    #1;
    check("r7_stored", bus.rd1, 32'hDEAD_BEEF);
    check("r3_stored", bus.rd2, 32'h0000_0055);

    // mid-cycle reset clears everything immediately
    #2;
    rst = 1'b0;
    #1;
    check("midrst_r3", bus.rd1, 32'h0);
    check("midrst_cnt", 32'(bus.wr_count), 32'h0);
    // write held across an edge while in reset is lost
    drive(1'b1, 1'b0, 5'd4, 32'h0000_0099, 32'h0, 5'd4, 5'd3);
    #1;
    check("rst_bypass_off", bus.rd1, 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd4, 5'd3);
    rst = 1'b1;
    #1;
    check("rst_write_lost", bus.rd1, 32'h0);
    check("r3_after_release", bus.rd2, 32'h0);
    check("cnt_after_release", 32'(bus.wr_count), 32'h0);
    @(posedge clk);
    #1;
    check("r3_still_zero", bus.rd2, 32'h0);

    // first honoured write after release
    drive(1'b1, 1'b0, 5'd3, 32'h0000_0077, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0);
    #1;
    check("r3_rewritten", bus.rd1, 32'h0000_0077);
    check("cnt_one", 32'(bus.wr_count), 32'h1);

    // counter wrap: 65534 more writes reach 0xFFFF, one more wraps to 0
    drive(1'b1, 1'b0, 5'd2, 32'h0000_0ABC, 32'h0, 5'd2, 5'd0);
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_ffff", 32'(bus.wr_count), 32'h0000_FFFF);
    @(posedge clk);
    #1;
    check("cnt_wrap", 32'(bus.wr_count), 32'h0);
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0, 5'd2, 5'd0);
    @(posedge clk);
    #1;
    check("cnt_r0_discard", 32'(bus.wr_count), 32'h0);
    check("r2_value", bus.rd1, 32'h0000_0ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001: Parameter DATA_W, default 32, width of register data, result and writeback inputs.
REQ-002: Parameter NREG, default 32, number of architectural registers, addressed by 5-bit fields.
REQ-003: Parameter CNT_W, default 16, width of the committed-write counter.
REQ-004: clk  input  1  clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, asynchronous, active-low.
REQ-006: ReadDataW  input  DATA_W  load data from the MEM/WB register.
REQ-007: AluoutW  input  DATA_W  ALU result from the MEM/WB register.
REQ-008: writeRegW  input  5  destination register number.
REQ-009: RegWriteW  input  1  writeback enable.
REQ-010: MemtoRegW  input  1  result select; 1 = ReadDataW, 0 = AluoutW.
REQ-011: ra1  input  5  decode read address, port 1.
REQ-012: ra2  input  5  decode read address, port 2.
REQ-013: rd1  output  DATA_W  read data, port 1, combinational.
REQ-014: rd2  output  DATA_W  read data, port 2, combinational.
REQ-015: ResultW  output  DATA_W  selected writeback value, combinational.
REQ-016: wr_count  output  CNT_W  number of committed register writes, registered.

Function
REQ-017: ResultW SHALL equal ReadDataW when MemtoRegW=1, else AluoutW, every cycle regardless of RegWriteW.
REQ-018: An effective write SHALL occur when RegWriteW=1 and writeRegW!=0.
REQ-019: On an effective write, reg[writeRegW] SHALL take ResultW at the rising clk edge; no other register changes.
REQ-020: Writes with writeRegW=0 SHALL be discarded; reg[0] SHALL always read 0.
REQ-021: rdN SHALL return 0 when raN=0.
REQ-022: rdN SHALL return ResultW when raN=writeRegW, raN!=0 and RegWriteW=1 (same-cycle write-through bypass).
REQ-023: Otherwise rdN SHALL return reg[raN] as stored before the current edge.
REQ-024: ra1 and ra2 SHALL be independent; equal addresses SHALL return identical data on both ports, including the bypass case.
REQ-025: wr_count SHALL increment by 1 on each effective write edge and SHALL NOT change on discarded writes.
REQ-026: wr_count SHALL wrap from 2^CNT_W-1 to 0 without a flag.
REQ-027: Write latency: data written at edge N SHALL be visible from the array (non-bypass path) immediately after edge N.
REQ-028: X or unknown values on AluoutW/ReadDataW with RegWriteW=0 SHALL NOT alter any register.

Reset
REQ-029: While rst=0, all registers reg[1..NREG-1] SHALL be 0 and wr_count SHALL be 0, asynchronously, independent of clk.
REQ-030: While rst=0, rd1/rd2 SHALL read 0 for any address, and the bypass SHALL be suppressed.
REQ-031: A write coinciding with the clk edge at which rst is low SHALL be lost; the first write honoured is at the first rising edge with rst=1.
REQ-032: Reset asserted mid-operation SHALL clear all state within the same cycle; no partial writes survive.

Verification
REQ-033: Reset, then RegWriteW=1, writeRegW=5, MemtoRegW=0, AluoutW=0x0000_1234 for one edge; ra1=5 -> rd1=0x0000_1234, wr_count=1.
REQ-034: RegWriteW=1, writeRegW=0, AluoutW=0xFFFF_FFFF; ra1=0 -> rd1=0 before and after edge, wr_count unchanged.
REQ-035: reg7=0x11; same cycle RegWriteW=1, writeRegW=7, MemtoRegW=1, ReadDataW=0xDEAD_BEEF, ra1=ra2=7 -> rd1=rd2=0xDEAD_BEEF before the edge, stored value 0xDEAD_BEEF after.
REQ-036: MemtoRegW toggled with RegWriteW=0, AluoutW=0xA, ReadDataW=0xB -> ResultW follows 0xA/0xB, no register change, wr_count unchanged.
REQ-037: Preload wr_count to 0xFFFF via 65535 writes, one more effective write -> wr_count=0x0000.
REQ-038: Write reg3=0x55, assert rst low between edges -> rd for ra1=3 reads 0 immediately, wr_count=0; after release, rd1 stays 0 until a new write.
